sweep_stimulus_gen: RTL and testbench

Synthesizable stepped-frequency sine stimulus source with optional additive LFSR noise. It feeds `data_in` of `iir_filter` in sweep tests and on-chip self-test. A control FSM steps a DDS phase increment from a programmed start value through N steps, each held for a programmable dwell, optionally looping. A quarter-wave LUT produces the sine, and the source output is saturated, so it never wraps.

---
 rtl/sweep_stimulus_gen.sv | 256 +++++++++++++++++++++++++
 tb/tb_sweep_stimulus_gen.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sweep_stimulus_gen.sv
// sweep_stimulus_gen: stepped-frequency DDS sine source with optional LFSR noise.
// Control FSM steps the phase increment through a programmed sweep. A quarter-wave
// LUT and a two-register pipeline produce a saturated signed sample stream with
// aligned valid/strobe/index side-band.
module sweep_stimulus_gen #(
    parameter int DATA_WIDTH    = 16,
    parameter int N             = 32,
    parameter int LUT_ADDR_BITS = 8,
    parameter int DWELL_WIDTH   = 16,
    parameter int STEP_WIDTH    = 8,
    parameter int NOISE_SHIFT   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [N-1:0]           start_fcw,
    input  logic [N-1:0]           step_fcw,
    input  logic [STEP_WIDTH-1:0]  num_steps,
    input  logic [DWELL_WIDTH-1:0] dwell_cycles,
    input  logic                   loop_en,
    input  logic                   noise_en,
    output logic [DATA_WIDTH-1:0]  sample_out,
    output logic                   sample_valid,
    output logic                   busy,
    output logic                   step_strobe,
    output logic [STEP_WIDTH-1:0]  step_idx,
    output logic                   done
);

    localparam int LUT_DEPTH = 1 << LUT_ADDR_BITS;
    // Sum width: room for the wider of sine/noise plus sign growth.
    localparam int SW = ((DATA_WIDTH > 16) ? DATA_WIDTH : 16) + 2;
    localparam logic signed [SW-1:0] SAT_MAX = SW'((2 ** (DATA_WIDTH - 1)) - 1);
    localparam logic signed [SW-1:0] SAT_MIN = -SAT_MAX - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Elaboration-time sine: Taylor series is exact to double precision on [0, pi/2].
    function automatic int f_lut_val(input int idx);
        real x;
        real term;
        real acc;
        real amp;
        amp  = real'((2 ** (DATA_WIDTH - 1)) - 1);
        x    = (3.14159265358979323846 / 2.0) * (real'(idx) + 0.5) / real'(LUT_DEPTH);
        term = x;
        acc  = x;
        for (int k = 1; k < 12; k++) begin
            term = -term * x * x / real'((2 * k) * (2 * k + 1));
            acc  = acc + term;
        end
        return $rtoi(amp * acc + 0.5);
    endfunction

    logic [DATA_WIDTH-1:0] w_lut [LUT_DEPTH];

    for (genvar gi = 0; gi < LUT_DEPTH; gi++) begin : g_lut
        localparam int VAL = f_lut_val(gi);
        assign w_lut[gi] = VAL[DATA_WIDTH-1:0];
    end

    state_t r_state;
    state_t w_state_nxt;

    // Latched sweep configuration
    logic [N-1:0]           r_start_fcw;
    logic [N-1:0]           r_step_fcw;
    logic [STEP_WIDTH-1:0]  r_last_step;
    logic [DWELL_WIDTH-1:0] r_last_dwell;
    logic                   r_loop;
    logic                   r_noise_en;

    // Sweep state
    logic [N-1:0]           r_phase;
    logic [N-1:0]           r_fcw;
    logic [STEP_WIDTH-1:0]  r_step_cnt;
    logic [DWELL_WIDTH-1:0] r_dwell_cnt;
    logic [15:0]            r_lfsr;

    // Pipeline side-band; index 1 = LUT stage, index 2 = output stage, last[3] = done
    logic [2:1]                 r_vld_pipe;
    logic [2:1]                 r_stb_pipe;
    logic [2:1][STEP_WIDTH-1:0] r_idx_pipe;
    logic [3:1]                 r_last_pipe;
    logic [DATA_WIDTH-1:0]      r_lut;
    logic                       r_neg;
    logic [15:0]                r_noise;
    logic [DATA_WIDTH-1:0]      r_sample;

    logic w_busy;
    logic w_run;
    logic w_start_ok;
    logic w_flush;
    logic w_dwell_end;
    logic w_last_step;
    logic w_finish;

    logic [LUT_ADDR_BITS-1:0] w_a;
    logic [LUT_ADDR_BITS-1:0] w_addr;
    logic signed [15:0]       w_noise_sh;
    logic signed [SW-1:0]     w_sine_s;
    logic signed [SW-1:0]     w_noise_s;
    logic signed [SW-1:0]     w_sum;
    logic [DATA_WIDTH-1:0]    w_sat;

    // busy covers the pipeline drain and the done cycle so a new start never
    // overlaps samples of the previous sweep.
    assign w_busy      = (r_state != S_IDLE) | (|r_vld_pipe) | (|r_last_pipe);
    assign w_run       = (r_state == S_RUN);
    assign w_dwell_end = w_run && (r_dwell_cnt == r_last_dwell);
    assign w_last_step = (r_step_cnt == r_last_step);
    assign w_flush     = abort && w_busy;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state and sweep control decode
    always_comb begin
        w_state_nxt = r_state;
        w_start_ok  = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !abort && !w_busy) begin
                    w_state_nxt = S_RUN;
                    w_start_ok  = 1'b1;
                end
            end
            S_RUN: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_dwell_end && w_last_step && !r_loop) begin
                    w_state_nxt = S_DONE;
                    w_finish    = 1'b1;
                end
            end
            S_DONE:  w_state_nxt = abort ? S_IDLE : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Config latch, phase accumulator, FCW stepping and dwell/step counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_start_fcw  <= '0;
            r_step_fcw   <= '0;
            r_last_step  <= '0;
            r_last_dwell <= '0;
            r_loop       <= 1'b0;
            r_noise_en   <= 1'b0;
            r_phase      <= '0;
            r_fcw        <= '0;
            r_step_cnt   <= '0;
            r_dwell_cnt  <= '0;
        end else if (w_start_ok) begin
            r_start_fcw  <= start_fcw;
            r_step_fcw   <= step_fcw;
            r_last_step  <= (num_steps == '0) ? '0 : num_steps - 1'b1;
            r_last_dwell <= (dwell_cycles == '0) ? '0 : dwell_cycles - 1'b1;
            r_loop       <= loop_en;
            r_noise_en   <= noise_en;
            r_phase      <= '0;
            r_fcw        <= start_fcw;
            r_step_cnt   <= '0;
            r_dwell_cnt  <= '0;
        end else if (w_run && !abort) begin
            r_phase <= r_phase + r_fcw;
            if (w_dwell_end) begin
                r_dwell_cnt <= '0;
                if (w_last_step) begin
                    // Loop wrap: phase keeps running so the sweep stays continuous
                    r_fcw      <= r_start_fcw;
                    r_step_cnt <= '0;
                end else begin
                    r_fcw      <= r_fcw + r_step_fcw;
                    r_step_cnt <= r_step_cnt + 1'b1;
                end
            end else begin
                r_dwell_cnt <= r_dwell_cnt + 1'b1;
            end
        end
    end

    // Galois LFSR x^16+x^14+x^13+x^11+1, free-running while the FSM is active
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    r_lfsr <= 16'hACE1;
        else if (r_state != S_IDLE) r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    // Quadrant folding: odd quadrants read the table mirrored
    assign w_a    = r_phase[N-3 -: LUT_ADDR_BITS];
    assign w_addr = r_phase[N-2] ? ~w_a : w_a;

    assign w_noise_sh = $signed(r_noise) >>> NOISE_SHIFT;

    // Sign, noise add and saturation for the output stage
    always_comb begin
        w_sine_s = $signed({{(SW-DATA_WIDTH){1'b0}}, r_lut});
        if (r_neg) w_sine_s = -w_sine_s;
        w_noise_s = r_noise_en ? $signed({{(SW-16){w_noise_sh[15]}}, w_noise_sh}) : '0;
        w_sum     = w_sine_s + w_noise_s;
        w_sat     = w_sum[DATA_WIDTH-1:0];
        if (w_sum > SAT_MAX)      w_sat = SAT_MAX[DATA_WIDTH-1:0];
        else if (w_sum < SAT_MIN) w_sat = SAT_MIN[DATA_WIDTH-1:0];
    end

    // Two-stage sample pipeline with side-band; abort discards everything in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_pipe  <= '0;
            r_stb_pipe  <= '0;
            r_idx_pipe  <= '0;
            r_last_pipe <= '0;
            r_lut       <= '0;
            r_neg       <= 1'b0;
            r_noise     <= '0;
            r_sample    <= '0;
        end else if (w_flush) begin
            r_vld_pipe  <= '0;
            r_stb_pipe  <= '0;
            r_idx_pipe  <= '0;
            r_last_pipe <= '0;
            r_sample    <= '0;
        end else begin
            r_vld_pipe[1]  <= w_run;
            r_stb_pipe[1]  <= w_run && (r_dwell_cnt == '0);
            r_idx_pipe[1]  <= w_run ? r_step_cnt : '0;
            r_last_pipe[1] <= w_finish;
            r_lut          <= w_lut[w_addr];
            r_neg          <= r_phase[N-1];
            r_noise        <= r_lfsr;

            r_vld_pipe[2]    <= r_vld_pipe[1];
            r_stb_pipe[2]    <= r_stb_pipe[1];
            r_idx_pipe[2]    <= r_idx_pipe[1];
            r_last_pipe[3:2] <= r_last_pipe[2:1];
            r_sample         <= r_vld_pipe[1] ? w_sat : '0;
        end
    end

    assign sample_out   = r_sample;
    assign sample_valid = r_vld_pipe[2];
    assign step_strobe  = r_stb_pipe[2];
    assign step_idx     = r_idx_pipe[2];
    assign done         = r_last_pipe[3];
    assign busy         = w_busy;

endmodule

// File: tb/tb_sweep_stimulus_gen.sv
// Scoreboard bench for sweep_stimulus_gen (built with NOISE_SHIFT=0).
module tb_sweep_stimulus_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] start_fcw = '0;
    logic [31:0] step_fcw = '0;
    logic [7:0]  num_steps = '0;
    logic [15:0] dwell_cycles = '0;
    logic        loop_en = 1'b0;
    logic        noise_en = 1'b0;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic        busy;
    logic        step_strobe;
    logic [7:0]  step_idx;
    logic        done;

    always #5 clk = ~clk;

    sweep_stimulus_gen #(.NOISE_SHIFT(0)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .start_fcw(start_fcw), .step_fcw(step_fcw), .num_steps(num_steps),
        .dwell_cycles(dwell_cycles), .loop_en(loop_en), .noise_en(noise_en),
        .sample_out(sample_out), .sample_valid(sample_valid), .busy(busy),
        .step_strobe(step_strobe), .step_idx(step_idx), .done(done)
    );

    typedef struct {
        logic [15:0] s;
        logic [7:0]  idx;
        logic        stb;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail = 0;
    int   mon_nvalid = 0;
    int   mon_ndone = 0;

    // Scoreboard: every valid sample pops one expectation; idle output must be 0
    always @(negedge clk) begin
        if (done) mon_ndone++;
        if (sample_valid) begin
            mon_nvalid++;
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_sample: got %0d, expected no sample", $signed(sample_out));
            end else begin
                mon_e = exp_q.pop_front();
                if (sample_out !== mon_e.s || step_idx !== mon_e.idx || step_strobe !== mon_e.stb) begin
                    n_fail++;
                    $display("FAIL sample: got s=%0d idx=%0d stb=%0b, expected s=%0d idx=%0d stb=%0b",
                             $signed(sample_out), step_idx, step_strobe, $signed(mon_e.s), mon_e.idx, mon_e.stb);
                end
            end
        end else if (!rst) begin
            n_tests++;
            if (sample_out !== 16'h0000) begin
                n_fail++;
                $display("FAIL idle_zero: got %0d, expected 0", $signed(sample_out));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int m_sine(input logic [31:0] ph);
        int a;
        int v;
        a = int'(ph[29:22]);
        if (ph[30]) a = 255 - a;
        v = $rtoi(32767.0 * $sin(3.14159265358979 / 2.0 * (real'(a) + 0.5) / 256.0) + 0.5);
        return ph[31] ? -v : v;
    endfunction

    function automatic int m_raw(input logic [31:0] ph, input logic [15:0] lf, input bit nz);
        return m_sine(ph) + (nz ? int'($signed(lf)) : 0);
    endfunction

    function automatic logic [15:0] m_sat(input int raw);
        if (raw > 32767)  return 16'h7FFF;
        if (raw < -32768) return 16'h8000;
        return 16'(raw);
    endfunction

    function automatic logic [15:0] m_lfsr_next(input logic [15:0] l);
        return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    endfunction

    // Push the expected sample stream of a sweep (LFSR assumed fresh from reset)
    task automatic push_sweep(input logic [31:0] sf, input logic [31:0] stf, input int ns, input int dw,
                              input bit lp, input bit nz, input int count, output int n_max);
        logic [31:0] ph;
        logic [31:0] fcw;
        logic [15:0] lf;
        int st;
        int d;
        exp_t e;
        ph = '0; fcw = sf; lf = 16'hACE1; st = 0; d = 0; n_max = 0;
        if (ns == 0) ns = 1;
        if (dw == 0) dw = 1;
        for (int k = 0; k < count; k++) begin
            e.s   = m_sat(m_raw(ph, lf, nz));
            e.idx = 8'(st);
            e.stb = (d == 0);
            if (e.s == 16'h7FFF) n_max++;
            exp_q.push_back(e);
            ph = ph + fcw;
            lf = m_lfsr_next(lf);
            d++;
            if (d == dw) begin
                d = 0;
                if (st == ns - 1) begin
                    if (lp) begin fcw = sf; st = 0; end
                end else begin
                    fcw = fcw + stf; st++;
                end
            end
        end
    endtask

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic kick(input logic [31:0] sf, input logic [31:0] stf, input int ns, input int dw,
                        input bit lp, input bit nz);
        @(negedge clk);
        start_fcw = sf; step_fcw = stf; num_steps = 8'(ns); dwell_cycles = 16'(dw);
        loop_en = lp; noise_en = nz; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    // Observe from the negedge after kick until busy drops; cycle 1 = kick's return
    task automatic run_until_idle(input int max, output int nv, output int nd, output int nstb,
                                  output int first_v, output int last_v, output int done_c,
                                  output logic [15:0] first_s, output int n_max, output bit tmo);
        int cyc;
        cyc = 1; nv = 0; nd = 0; nstb = 0; first_v = -1; last_v = -1; done_c = -1;
        first_s = '0; n_max = 0; tmo = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (sample_valid) begin
                if (nv == 0) begin first_v = cyc; first_s = sample_out; end
                nv++;
                last_v = cyc;
                if (sample_out == 16'h7FFF) n_max++;
            end
            if (step_strobe) nstb++;
            if (done) begin nd++; done_c = cyc; end
            if (!busy) break;
            if (cyc >= max) begin tmo = 1; break; end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_tests++;
        if ({sample_out, sample_valid, busy, step_strobe, step_idx, done} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, expected 0", {sample_out, sample_valid, busy, step_strobe, step_idx, done});
        end
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || sample_valid !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got busy=%0b valid=%0b done=%0b, expected 0", busy, sample_valid, done);
        end
    endtask

    task automatic test_quadrants();
        exp_t e;
        int nv, nd, nstb, fv, lv, dc, nm;
        logic [15:0] fs;
        bit tmo;
        e.idx = 8'd0;
        e.s = 16'd101;    e.stb = 1'b1; exp_q.push_back(e);
        e.s = 16'h7FFF;   e.stb = 1'b0; exp_q.push_back(e);
        e.s = 16'hFF9B;   exp_q.push_back(e);
        e.s = 16'h8001;   exp_q.push_back(e);
        kick(32'h4000_0000, 32'd0, 1, 4, 1'b0, 1'b0);
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_rise: got %0b, expected 1", busy); end
        run_until_idle(50, nv, nd, nstb, fv, lv, dc, fs, nm, tmo);
        n_tests++;
        if (tmo || nv != 4 || fv != 3 || lv != 6) begin
            n_fail++;
            $display("FAIL quad_timing: got nv=%0d first=%0d last=%0d tmo=%0b, expected 4/3/6/0", nv, fv, lv, tmo);
        end
        n_tests++;
        if (nd != 1 || dc != 7) begin
            n_fail++;
            $display("FAIL quad_done: got count=%0d cyc=%0d, expected 1/7", nd, dc);
        end
        n_tests++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL quad_drain: got %0d left, expected 0", exp_q.size()); end
    endtask

    task automatic test_multistep();
        int nv, nd, nstb, fv, lv, dc, nm, dummy;
        logic [15:0] fs;
        bit tmo;
        push_sweep(32'd89478485, 32'd89478485, 3, 5, 1'b0, 1'b0, 15, dummy);
        kick(32'd89478485, 32'd89478485, 3, 5, 1'b0, 1'b0);
        run_until_idle(100, nv, nd, nstb, fv, lv, dc, fs, nm, tmo);
        n_tests++;
        if (tmo || nv != 15 || nstb != 3) begin
            n_fail++;
            $display("FAIL multistep_count: got nv=%0d strobes=%0d, expected 15/3", nv, nstb);
        end
        n_tests++;
        if (nd != 1 || dc != lv + 1) begin
            n_fail++;
            $display("FAIL multistep_done: got count=%0d cyc=%0d, expected 1/%0d", nd, dc, lv + 1);
        end
        n_tests++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL multistep_drain: got %0d left, expected 0", exp_q.size()); end
    endtask

    task automatic test_loop_abort();
        int cnt, dummy, d0, seen;
        push_sweep(32'h1000_0000, 32'h0100_0000, 2, 3, 1'b1, 1'b0, 10, dummy);
        d0 = mon_ndone;
        kick(32'h1000_0000, 32'h0100_0000, 2, 3, 1'b1, 1'b0);
        cnt = 0;
        for (int c = 0; c < 60 && cnt < 10; c++) begin
            @(negedge clk);
            if (sample_valid) cnt++;
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_tests++;
        if (cnt != 10 || sample_valid !== 1'b0 || sample_out !== 16'h0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_now: got cnt=%0d valid=%0b out=%0d busy=%0b, expected 10/0/0/0",
                     cnt, sample_valid, $signed(sample_out), busy);
        end
        seen = 0;
        repeat (8) begin @(negedge clk); if (busy) seen++; end
        n_tests++;
        if (mon_ndone != d0 || seen != 0) begin
            n_fail++;
            $display("FAIL abort_quiet: got done=%0d busy_cycles=%0d, expected 0/0", mon_ndone - d0, seen);
        end
        n_tests++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL loop_drain: got %0d left, expected 0", exp_q.size()); end
    endtask

    task automatic test_noise_sat();
        int nv, nd, nstb, fv, lv, dc, nm, exp_nm;
        logic [15:0] fs;
        bit tmo;
        do_reset();
        push_sweep(32'h4000_0000, 32'd0, 1, 64, 1'b0, 1'b1, 64, exp_nm);
        kick(32'h4000_0000, 32'd0, 1, 64, 1'b0, 1'b1);
        run_until_idle(200, nv, nd, nstb, fv, lv, dc, fs, nm, tmo);
        n_tests++;
        if (fs !== 16'hAD46) begin
            n_fail++;
            $display("FAIL noise_first: got %0d, expected -21178", $signed(fs));
        end
        n_tests++;
        if (tmo || nv != 64 || nm != exp_nm) begin
            n_fail++;
            $display("FAIL noise_clamp: got nv=%0d clamps=%0d, expected 64/%0d", nv, nm, exp_nm);
        end
        n_tests++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL noise_drain: got %0d left, expected 0", exp_q.size()); end
    endtask

    task automatic test_edge_cases();
        int nv, nd, nstb, fv, lv, dc, nm, dummy, v0, d0, seen;
        logic [15:0] fs;
        bit tmo;
        // zero steps and zero dwell behave as one of each
        push_sweep(32'h4000_0000, 32'd0, 0, 0, 1'b0, 1'b0, 1, dummy);
        kick(32'h4000_0000, 32'd0, 0, 0, 1'b0, 1'b0);
        run_until_idle(50, nv, nd, nstb, fv, lv, dc, fs, nm, tmo);
        n_tests++;
        if (tmo || nv != 1 || fv != 3 || nd != 1 || dc != 4) begin
            n_fail++;
            $display("FAIL zero_cfg: got nv=%0d first=%0d done=%0d@%0d, expected 1/3/1@4", nv, fv, nd, dc);
        end
        // start while busy with different inputs must not disturb the sweep
        push_sweep(32'h1000_0000, 32'h0400_0000, 2, 4, 1'b0, 1'b0, 8, dummy);
        v0 = mon_nvalid; d0 = mon_ndone;
        kick(32'h1000_0000, 32'h0400_0000, 2, 4, 1'b0, 1'b0);
        start_fcw = 32'h7777_7777; num_steps = 8'd9; dwell_cycles = 16'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 100 && busy; c++) @(negedge clk);
        n_tests++;
        if (busy || mon_nvalid - v0 != 8 || mon_ndone - d0 != 1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL start_busy: got valid=%0d done=%0d left=%0d, expected 8/1/0",
                     mon_nvalid - v0, mon_ndone - d0, exp_q.size());
        end
        // start and abort together in idle: abort wins
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        seen = busy ? 1 : 0;
        repeat (5) begin @(negedge clk); if (busy || sample_valid) seen++; end
        n_tests++;
        if (seen != 0) begin n_fail++; $display("FAIL start_abort: got %0d active cycles, expected 0", seen); end
    endtask

    task automatic test_async_reset();
        int nv, nd, nstb, fv, lv, dc, nm, dummy, v0;
        logic [15:0] fs;
        bit tmo;
        do_reset();
        push_sweep(32'h0345_6789, 32'h0222_0000, 3, 8, 1'b0, 1'b1, 24, dummy);
        v0 = mon_nvalid;
        kick(32'h0345_6789, 32'h0222_0000, 3, 8, 1'b0, 1'b1);
        for (int c = 0; c < 50 && (mon_nvalid - v0) < 10; c++) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({sample_out, sample_valid, busy, step_strobe, step_idx, done} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got %h, expected 0", {sample_out, sample_valid, busy, step_strobe, step_idx, done});
        end
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        push_sweep(32'h0345_6789, 32'h0222_0000, 3, 8, 1'b0, 1'b1, 24, dummy);
        kick(32'h0345_6789, 32'h0222_0000, 3, 8, 1'b0, 1'b1);
        run_until_idle(100, nv, nd, nstb, fv, lv, dc, fs, nm, tmo);
        n_tests++;
        if (tmo || nv != 24 || nd != 1 || nstb != 3 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL replay: got nv=%0d done=%0d strobes=%0d left=%0d, expected 24/1/3/0",
                     nv, nd, nstb, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_quadrants();
        test_multistep();
        test_loop_abort();
        test_noise_sat();
        test_edge_cases();
        test_async_reset();
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
